// File: rtl/dt_integrator.sv
// dT-to-temperature integrator: accumulates clamped, scaled Q7.0 slope samples
// into a saturating Q7.0 trajectory behind a 1-entry valid/ready output stage.
module dt_integrator #(
  parameter int CNT_W = 16,
  parameter int K_MAX = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [7:0]       T_seed,
  input  logic [7:0]       dT_in,
  input  logic             dt_in_valid,
  output logic             dt_in_ready,
  input  logic [7:0]       k_dt,
  input  logic [7:0]       d_max,
  output logic [7:0]       T_out,
  output logic             t_valid,
  input  logic             t_ready,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [7:0] t;
    logic       hi;
    logic       lo;
  } upd_t;

  state_t            state, state_next;
  logic [7:0]        t_acc;
  logic              accept;
  upd_t              upd;

  logic [8:0]        dmax;
  logic [8:0]        dhi;
  logic signed [9:0] dt_s, lo_lim, hi_lim, clamp_s;
  logic [7:0]        clamped;
  logic [7:0]        k_lim;
  logic [15:0]       step;
  logic signed [16:0] sum;

  // Slope clamp: negative bound may reach -128, positive bound stops at +127.
  always_comb begin
    dmax    = (d_max > 8'd128) ? 9'd128 : {1'b0, d_max};
    dhi     = (dmax > 9'd127) ? 9'd127 : dmax;
    dt_s    = {{2{dT_in[7]}}, dT_in};
    lo_lim  = -$signed({1'b0, dmax});
    hi_lim  = $signed({1'b0, dhi});
    clamp_s = (dt_s < lo_lim) ? lo_lim : (dt_s > hi_lim) ? hi_lim : dt_s;
    clamped = clamp_s[7:0];
    k_lim   = (k_dt > 8'(K_MAX)) ? 8'(K_MAX) : k_dt;
    step    = {{8{clamped[7]}}, clamped} <<< k_lim;
    sum     = $signed({{9{t_acc[7]}}, t_acc}) + $signed({step[15], step});
    upd.hi  = (sum > 17'sd127);
    upd.lo  = (sum < -17'sd128);
    upd.t   = upd.hi ? 8'h7f : upd.lo ? 8'h80 : sum[7:0];
  end

  always_comb begin
    state_next  = state;
    if (init) state_next = RUN;
    dt_in_ready = (state == RUN) && !init && (!t_valid || t_ready);
    accept      = dt_in_valid && dt_in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // T_out always mirrors the accumulator: both load on init and on accept only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_acc      <= '0;
      t_valid    <= 1'b0;
      sat_hi     <= 1'b0;
      sat_lo     <= 1'b0;
      sample_cnt <= '0;
    end else if (init) begin
      t_acc      <= T_seed;
      t_valid    <= 1'b0;
      sat_hi     <= 1'b0;
      sat_lo     <= 1'b0;
      sample_cnt <= '0;
    end else if (accept) begin
      t_acc      <= upd.t;
      t_valid    <= 1'b1;
      sat_hi     <= upd.hi;
      sat_lo     <= upd.lo;
      if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
    end else if (t_valid && t_ready) begin
      t_valid    <= 1'b0;
    end
  end

  assign T_out = t_acc;

endmodule

// File: tb/tb_dt_integrator.sv
// Bench for dt_integrator: directed scenarios with literal expectations plus a
// long randomized run, all checked cycle by cycle against an arithmetic model.
module tb_dt_integrator;
  localparam int CNT_W = 16;
  localparam int K_MAX = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             init;
  logic [7:0]       T_seed, dT_in, k_dt, d_max;
  logic             dt_in_valid, dt_in_ready;
  logic [7:0]       T_out;
  logic             t_valid, t_ready, sat_hi, sat_lo;
  logic [CNT_W-1:0] sample_cnt;

  dt_integrator #(.CNT_W(CNT_W), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .T_seed(T_seed), .dT_in(dT_in),
    .dt_in_valid(dt_in_valid), .dt_in_ready(dt_in_ready), .k_dt(k_dt),
    .d_max(d_max), .T_out(T_out), .t_valid(t_valid), .t_ready(t_ready),
    .sat_hi(sat_hi), .sat_lo(sat_lo), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit m_run;
  int m_t;
  bit m_valid, m_hi, m_lo;
  int m_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_run && !init && (!m_valid || t_ready);
  endfunction

  task automatic m_reset();
    m_run = 0; m_t = 0; m_valid = 0; m_hi = 0; m_lo = 0; m_cnt = 0;
  endtask

  // Next state from the pre-edge inputs, using plain integer arithmetic.
  task automatic m_step();
    int d, dh, x, k, s;
    if (init) begin
      m_run = 1; m_t = $signed(T_seed); m_valid = 0; m_hi = 0; m_lo = 0; m_cnt = 0;
    end else if (dt_in_valid && m_ready()) begin
      d  = (d_max > 128) ? 128 : int'(d_max);
      dh = (d > 127) ? 127 : d;
      x  = $signed(dT_in);
      if (x < -d) x = -d;
      if (x > dh) x = dh;
      k  = (k_dt > K_MAX) ? K_MAX : int'(k_dt);
      s  = m_t + x * (1 << k);
      m_hi = (s > 127);
      m_lo = (s < -128);
      m_t  = m_hi ? 127 : (m_lo ? -128 : s);
      m_valid = 1;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else if (m_valid && t_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic cmp_all();
    chk("dt_in_ready", dt_in_ready, m_ready());
    chk("t_valid", t_valid, m_valid);
    chk("T_out", $signed(T_out), m_t);
    chk("sat_hi", sat_hi, m_hi);
    chk("sat_lo", sat_lo, m_lo);
    chk("sample_cnt", sample_cnt, m_cnt);
  endtask

  // Called at a negedge with inputs just set; returns at the following negedge.
  task automatic tick();
    #1;
    cmp_all();
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit in, input int seed, input bit v, input int dt,
                       input int k, input int dm, input bit rdy);
    init = in; T_seed = 8'(seed); dt_in_valid = v; dT_in = 8'(dt);
    k_dt = 8'(k); d_max = 8'(dm); t_ready = rdy;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst T_out", $signed(T_out), 0);
    chk("rst t_valid", t_valid, 0);
    chk("rst sat", {sat_hi, sat_lo}, 0);
    chk("rst cnt", sample_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 127, 1);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state with input offered but no init
    drive(0, 0, 1, 5, 0, 127, 1);
    repeat (4) tick();
    #1;
    chk("idle ready", dt_in_ready, 0);
    chk("idle t_valid", t_valid, 0);
    chk("idle T_out", $signed(T_out), 0);

    // Plain accumulation 20 -> 23,26,29,32
    drive(1, 20, 0, 0, 0, 127, 1); tick();
    drive(0, 0, 1, 3, 0, 127, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("ramp T_out", $signed(T_out), 20 + 3 * i);
      chk("ramp t_valid", t_valid, 1);
    end
    chk("ramp cnt", sample_cnt, 4);
    chk("ramp sat", {sat_hi, sat_lo}, 0);

    // Positive clamp + scale, then saturation both ways
    drive(1, 100, 0, 0, 2, 5, 1); tick();
    drive(0, 0, 1, 10, 2, 5, 1); tick();
    chk("scale T_out", $signed(T_out), 120);
    tick();
    chk("sathi T_out", $signed(T_out), 127);
    chk("sathi flag", sat_hi, 1);
    drive(1, -120, 0, 0, 0, 127, 1); tick();
    drive(0, 0, 1, -10, 0, 127, 1); tick();
    chk("satlo T_out", $signed(T_out), -128);
    chk("satlo flag", sat_lo, 1);
    chk("satlo hi clear", sat_hi, 0);

    // Backpressure: output frozen, then consume+accept in one cycle
    drive(1, 0, 0, 0, 0, 127, 1); tick();
    drive(0, 0, 1, 1, 0, 127, 1); tick();
    drive(0, 0, 1, 1, 0, 127, 0);
    #1 chk("bp ready", dt_in_ready, 0);
    tick(); tick();
    chk("bp T_out", $signed(T_out), 1);
    chk("bp t_valid", t_valid, 1);
    drive(0, 0, 1, 1, 0, 127, 1); tick();
    chk("bp resume T_out", $signed(T_out), 2);
    chk("bp resume cnt", sample_cnt, 2);

    // init drops pending output and ignores concurrent input
    drive(0, 0, 1, 1, 0, 127, 0); tick();
    drive(1, 50, 1, 1, 0, 127, 0);
    #1 chk("init ready", dt_in_ready, 0);
    tick();
    chk("init t_valid", t_valid, 0);
    chk("init T_out", $signed(T_out), 50);
    chk("init cnt", sample_cnt, 0);
    drive(0, 0, 1, 1, 0, 127, 1); tick();
    chk("post-init T_out", $signed(T_out), 51);

    // d_max=0: sample emitted with zero step; d_max above 128 lets -128 through
    drive(1, 10, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 50, 3, 0, 1); tick();
    chk("dmax0 T_out", $signed(T_out), 10);
    chk("dmax0 t_valid", t_valid, 1);
    drive(0, 0, 1, -128, 0, 200, 1); tick();
    chk("dmax200 T_out", $signed(T_out), -118);

    async_reset();

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 39) == 0), $urandom_range(0, 255),
            $urandom_range(0, 3) != 0, $urandom_range(0, 255),
            $urandom_range(0, 10), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255),
            $urandom_range(0, 9) < 7);
      tick();
      if ($urandom_range(0, 499) == 0) async_reset();
    end
    #1 cmp_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
